// File: rtl/hazard_pkg.sv
// Shared constants for the EX-stage hazard/forwarding logic.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Forward select encoding used by the EX operand muxes, the default
// register-address width, and the value a squashed (bubble) tag field
// takes.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write data
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

  // Every bit of a bubble tag is this value; an all-zero tag never
  // writes, never loads and never matches a forwarding source.
  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/fwd_select.sv
// Forward select for one EX operand: EX/MEM producer beats MEM/WB producer.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: src/src_used - operand tag in ID/EX; mem_* / wb_* - producer tags
// in EX/MEM and MEM/WB; sel - mux select (hazard_pkg FWD_* codes).
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a write to it is never a real producer.
  assign mem_hit = src_used && mem_regwrite && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = src_used && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller: tracks ID/EX, EX/MEM, MEM/WB dest tags, drives EX
//   forward selects, detects load-use and requests stall + ID/EX bubble.
// Latency: selects and stall are combinational; tags advance every cycle.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use.
//
// Ports: id_* - instruction currently in ID; ex_flush - taken branch in EX;
// ForwardA/ForwardB - operand selects; stall/idex_bubble - pipeline control;
// stall_count - saturating stall-cycle counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_flush,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              stall,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  // ID/EX tag
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_uses1, ex_uses2, ex_regwrite, ex_memread;
  // EX/MEM tag. The load flag is not kept here: a load can only reach
  // EX/MEM with its consumer behind a bubble, so nothing downstream of
  // ID/EX needs to know an instruction was a load.
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  // MEM/WB tag
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;

  logic load_use;
  logic idex_load;

  assign load_use = id_valid && ex_memread && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // A flush squashes the dependent instruction anyway, so it never stalls.
  assign stall       = load_use && !ex_flush;
  assign idex_bubble = stall || ex_flush;
  assign idex_load   = id_valid && !idex_bubble;

  always_ff @(posedge clk) begin
    if (rst || !idex_load) begin
      ex_rs1      <= {REG_AW{BUBBLE_BIT}};
      ex_rs2      <= {REG_AW{BUBBLE_BIT}};
      ex_rd       <= {REG_AW{BUBBLE_BIT}};
      ex_uses1    <= BUBBLE_BIT;
      ex_uses2    <= BUBBLE_BIT;
      ex_regwrite <= BUBBLE_BIT;
      ex_memread  <= BUBBLE_BIT;
    end else begin
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_uses1    <= id_uses_rs1;
      ex_uses2    <= id_uses_rs2;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd       <= {REG_AW{BUBBLE_BIT}};
      mem_regwrite <= BUBBLE_BIT;
      wb_rd        <= {REG_AW{BUBBLE_BIT}};
      wb_regwrite  <= BUBBLE_BIT;
    end else begin
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src          (ex_rs1),
    .src_used     (ex_uses1),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (ForwardA)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src          (ex_rs2),
    .src_used     (ex_uses2),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (ForwardB)
  );

endmodule
